// File: rtl/skid_pipeline_arbiter_if.sv
// Handshake bundle between REQ_COUNT ready/valid requesters, the arbiter and the pipeline input.
// The master view belongs to the arbiter; the slave view belongs to whatever surrounds it.
interface skid_pipeline_arbiter_if #(
   parameter int WORD_WIDTH = 8,
   parameter int REQ_COUNT  = 4
);
   localparam int SRC_W = ($clog2(REQ_COUNT) > 1) ? $clog2(REQ_COUNT) : 1;

   logic [REQ_COUNT-1:0]            req_valid;
   logic [REQ_COUNT-1:0]            req_ready;
   logic [REQ_COUNT*WORD_WIDTH-1:0] req_data;
   logic [REQ_COUNT-1:0]            req_last;
   logic                            pipe_valid;
   logic                            pipe_ready;
   logic [WORD_WIDTH-1:0]           pipe_data;
   logic                            pipe_last;
   logic [SRC_W-1:0]                pipe_source;
   logic                            grant_active;

   modport master (
      input  req_valid, req_data, req_last, pipe_ready,
      output req_ready, pipe_valid, pipe_data, pipe_last, pipe_source, grant_active
   );

   modport slave (
      output req_valid, req_data, req_last, pipe_ready,
      input  req_ready, pipe_valid, pipe_data, pipe_last, pipe_source, grant_active
   );
endinterface

// File: rtl/skid_pipeline_arbiter.sv
// Round-robin arbiter that shares one pipeline input among REQ_COUNT requesters, granting whole
// packets (or single words when PACKET_MODE=0) and tagging each word with its source index.
module skid_pipeline_arbiter #(
   parameter int WORD_WIDTH  = 8,
   parameter int REQ_COUNT   = 4,
   parameter bit PACKET_MODE = 1'b1
) (
   input logic                  clock,
   input logic                  clear_n,
   skid_pipeline_arbiter_if.master bus
);
   localparam int SRC_W = ($clog2(REQ_COUNT) > 1) ? $clog2(REQ_COUNT) : 1;
   localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(REQ_COUNT - 1);

   if (REQ_COUNT < 2) begin : g_count_check
      $error("skid_pipeline_arbiter: REQ_COUNT must be at least 2");
   end

   typedef enum logic {IDLE, GRANTED} state_t;

   state_t           state;
   logic [SRC_W-1:0] grant;
   logic [SRC_W-1:0] rr_ptr;
   logic             granted_q;

   logic [WORD_WIDTH-1:0] word [REQ_COUNT];
   logic                  any_valid;
   logic                  cur_valid;
   logic                  cur_last;
   logic                  xfer;

   for (genvar i = 0; i < REQ_COUNT; i++) begin : g_word
      assign word[i] = bus.req_data[i*WORD_WIDTH +: WORD_WIDTH];
   end

   // Explicit wrap keeps the ring correct for non-power-of-2 requester counts.
   function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + 1'b1;
   endfunction

   function automatic logic [SRC_W-1:0] pick(input logic [SRC_W-1:0]     start,
                                             input logic [REQ_COUNT-1:0] valid);
      logic [SRC_W-1:0] idx;
      logic [SRC_W-1:0] win;
      logic             found;
      idx   = start;
      win   = start;
      found = 1'b0;
      for (int k = 0; k < REQ_COUNT; k++) begin
         if (!found && valid[idx]) begin
            win   = idx;
            found = 1'b1;
         end
         idx = next_idx(idx);
      end
      return win;
   endfunction

   assign any_valid = |bus.req_valid;
   assign cur_valid = (state == GRANTED) && bus.req_valid[grant];
   assign cur_last  = bus.req_last[grant] | ~PACKET_MODE;
   assign xfer      = cur_valid & bus.pipe_ready;

   always_ff @(posedge clock or negedge clear_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!clear_n) begin
         state     <= IDLE;
         grant     <= '0;
         rr_ptr    <= '0;
         granted_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  grant     <= pick(rr_ptr, bus.req_valid);
                  state     <= GRANTED;
                  granted_q <= 1'b1;
               end
            end
            GRANTED: begin
               // Grant moves only on the transfer of a last word, so a stalled word never changes.
               if (xfer && cur_last) begin
                  rr_ptr <= next_idx(grant);
                  if (any_valid) begin
                     grant <= pick(next_idx(grant), bus.req_valid);
                  end else begin
                     state     <= IDLE;
                     granted_q <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               granted_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through this block infers a latch.
      bus.pipe_valid  = 1'b0;
      bus.pipe_data   = '0;
      bus.pipe_last   = 1'b0;
      bus.pipe_source = '0;
      bus.req_ready   = '0;
      if (state == GRANTED) begin
         bus.pipe_valid       = cur_valid;
         bus.pipe_data        = word[grant];
         bus.pipe_last        = cur_last;
         bus.pipe_source      = grant;
         bus.req_ready[grant] = bus.pipe_ready;
      end
   end

   assign bus.grant_active = granted_q;
endmodule
